// File: rtl/ras_pkg.sv
// ras_pkg: shared types and constants for the return address stack.
//   RAS_DEPTH        - number of stack entries (power of 2)
//   RAS_TARGET_WIDTH - stored return-target bits (matches the BTB target width)
//   ras_ckpt_t       - (ptr,count) checkpoint carried in branch info to the BRU
//   ras_op_e         - per-cycle stack operation after priority resolution
package ras_pkg;

  localparam int unsigned RAS_DEPTH        = 8;
  localparam int unsigned RAS_TARGET_WIDTH = 14;
  localparam int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);

  typedef logic [LOG_RAS_DEPTH-1:0]    ras_ptr_t;
  typedef logic [LOG_RAS_DEPTH:0]      ras_cnt_t;
  typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

  // Full-stack occupancy; count saturates here.
  localparam ras_cnt_t RAS_CNT_MAX = ras_cnt_t'(RAS_DEPTH);

  typedef struct packed {
    ras_ptr_t ptr;
    ras_cnt_t count;
  } ras_ckpt_t;

  typedef enum logic [2:0] {
    RAS_OP_IDLE    = 3'd0,
    RAS_OP_PUSH    = 3'd1,
    RAS_OP_POP     = 3'd2,
    RAS_OP_REPLACE = 3'd3,  // return-then-call: overwrite top in place
    RAS_OP_RESTORE = 3'd4
  } ras_op_e;

  // Resolve the request mix into one operation. Restore wins over everything;
  // pops on an empty stack are dropped, so push+pop on empty degrades to push.
  function automatic ras_op_e ras_decode_op(input logic restore,
                                            input logic push,
                                            input logic pop,
                                            input logic empty);
    ras_op_e op;
    op = RAS_OP_IDLE;
    if (restore) begin
      op = RAS_OP_RESTORE;
    end else if (push && pop && !empty) begin
      op = RAS_OP_REPLACE;
    end else if (push) begin
      op = RAS_OP_PUSH;
    end else if (pop && !empty) begin
      op = RAS_OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/ras.sv
// ras: return address stack for the fetch-stage branch predictor.
//   Pushes the return target on predicted calls, supplies the predicted
//   target on predicted returns, and exposes a (ptr,count) checkpoint that
//   the backend hands back on mispredict/flush.
// Ports:
//   CLK, RST       - clock; asynchronous active-high reset
//   push_valid     - predicted call: push push_target
//   push_target    - return address low bits
//   pop_valid      - predicted return: consume top
//   ret_target     - mem[top_ptr], combinational read of current state
//   ret_valid      - stack non-empty
//   ckpt_ptr       - top_ptr before this cycle's push/pop
//   ckpt_count     - count before this cycle's push/pop
//   restore_valid  - mispredict restore (overrides push/pop)
//   restore_ptr    - checkpointed top_ptr
//   restore_count  - checkpointed count
module ras
  import ras_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        push_valid,
  input  ras_target_t push_target,
  input  logic        pop_valid,
  output ras_target_t ret_target,
  output logic        ret_valid,
  output ras_ptr_t    ckpt_ptr,
  output ras_cnt_t    ckpt_count,
  input  logic        restore_valid,
  input  ras_ptr_t    restore_ptr,
  input  ras_cnt_t    restore_count
);

  ras_target_t mem_q [RAS_DEPTH];
  ras_ptr_t    top_q, top_d;
  ras_cnt_t    cnt_q, cnt_d;

  logic        wr_en;
  ras_ptr_t    wr_idx;
  logic        empty;
  ras_op_e     op;
  ras_ckpt_t   ckpt;

  assign empty = (cnt_q == '0);
  assign op    = ras_decode_op(restore_valid, push_valid, pop_valid, empty);

  // Read side: everything comes straight from the current state.
  assign ckpt       = '{ptr: top_q, count: cnt_q};
  assign ret_target = mem_q[top_q];
  assign ret_valid  = !empty;
  assign ckpt_ptr   = ckpt.ptr;
  assign ckpt_count = ckpt.count;

  // Next-state and write-port selection.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    unique case (op)
      RAS_OP_RESTORE: begin
        // Entries overwritten since the checkpoint stay as they are.
        top_d = restore_ptr;
        cnt_d = restore_count;
      end
      RAS_OP_PUSH: begin
        // Pointer wraps; on overflow the oldest entry is silently reused.
        top_d  = ras_ptr_t'(top_q + 1'b1);
        cnt_d  = (cnt_q == RAS_CNT_MAX) ? cnt_q : ras_cnt_t'(cnt_q + 1'b1);
        wr_en  = 1'b1;
        wr_idx = ras_ptr_t'(top_q + 1'b1);
      end
      RAS_OP_POP: begin
        top_d = ras_ptr_t'(top_q - 1'b1);
        cnt_d = ras_cnt_t'(cnt_q - 1'b1);
      end
      RAS_OP_REPLACE: begin
        wr_en  = 1'b1;
        wr_idx = top_q;
      end
      default: begin
      end
    endcase
  end

  // Pointer, occupancy and entry storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (wr_en) begin
        mem_q[wr_idx] <= push_target;
      end
    end
  end

  // A checkpoint can never describe more entries than the stack holds.
  a_restore_count_legal: assert property (
    @(posedge CLK) disable iff (RST)
      restore_valid |-> (restore_count <= RAS_CNT_MAX))
    else $error("ras: restore_count %0d exceeds depth", restore_count);

  a_ctrl_known: assert property (
    @(posedge CLK) disable iff (RST)
      !$isunknown({push_valid, pop_valid, restore_valid}))
    else $error("ras: X on request inputs");

endmodule

// File: tb/tb_ras.sv
// tb_ras: self-checking bench for ras. Directed scenarios followed by random
// push/pop/restore traffic, all compared against an array-based stack model.
module tb_ras;
  import ras_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        push_valid;
  ras_target_t push_target;
  logic        pop_valid;
  ras_target_t ret_target;
  logic        ret_valid;
  ras_ptr_t    ckpt_ptr;
  ras_cnt_t    ckpt_count;
  logic        restore_valid;
  ras_ptr_t    restore_ptr;
  ras_cnt_t    restore_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: circular array, top index and occupancy as plain ints.
  int m_mem [RAS_DEPTH];
  int m_ptr;
  int m_cnt;

  int ck_ptr_q[$];
  int ck_cnt_q[$];

  ras dut (
    .CLK           (CLK),
    .RST           (RST),
    .push_valid    (push_valid),
    .push_target   (push_target),
    .pop_valid     (pop_valid),
    .ret_target    (ret_target),
    .ret_valid     (ret_valid),
    .ckpt_ptr      (ckpt_ptr),
    .ckpt_count    (ckpt_count),
    .restore_valid (restore_valid),
    .restore_ptr   (restore_ptr),
    .restore_count (restore_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":ret_target"}, 32'(ret_target), 32'(m_mem[m_ptr]));
    chk({tag, ":ret_valid"},  32'(ret_valid),  32'(m_cnt != 0));
    chk({tag, ":ckpt_ptr"},   32'(ckpt_ptr),   32'(m_ptr));
    chk({tag, ":ckpt_count"}, 32'(ckpt_count), 32'(m_cnt));
  endtask

  task automatic check_const(input string tag, input int exp_tgt, input int exp_vld,
                             input int exp_ptr, input int exp_cnt);
    chk({tag, ":ret_target"}, 32'(ret_target), 32'(exp_tgt));
    chk({tag, ":ret_valid"},  32'(ret_valid),  32'(exp_vld));
    chk({tag, ":ckpt_ptr"},   32'(ckpt_ptr),   32'(exp_ptr));
    chk({tag, ":ckpt_count"}, 32'(ckpt_count), 32'(exp_cnt));
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(RAS_DEPTH); i++) m_mem[i] = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // Stack semantics: restore beats everything; a pop on empty does nothing;
  // a call+return pair replaces the top; a plain call overwrites the oldest
  // slot once the stack is full.
  task automatic model_step(input logic push, input int tgt, input logic pop,
                            input logic rv, input int rp, input int rc);
    int d;
    d = int'(RAS_DEPTH);
    if (rv) begin
      m_ptr = rp;
      m_cnt = rc;
    end else if (push && pop && m_cnt != 0) begin
      m_mem[m_ptr] = tgt;
    end else if (push) begin
      m_ptr = (m_ptr + 1) % d;
      m_mem[m_ptr] = tgt;
      m_cnt = (m_cnt + 1 > d) ? d : m_cnt + 1;
    end else if (pop && m_cnt != 0) begin
      m_ptr = (m_ptr + d - 1) % d;
      m_cnt = m_cnt - 1;
    end
  endtask

  task automatic idle_inputs();
    push_valid    = 1'b0;
    push_target   = '0;
    pop_valid     = 1'b0;
    restore_valid = 1'b0;
    restore_ptr   = '0;
    restore_count = '0;
  endtask

  // Called just after a rising edge: drive, check at falling edge, clock, advance model.
  task automatic cycle(input string tag, input logic push, input int tgt, input logic pop,
                       input logic rv, input int rp, input int rc);
    push_valid    = push;
    push_target   = ras_target_t'(tgt);
    pop_valid     = pop;
    restore_valid = rv;
    restore_ptr   = ras_ptr_t'(rp);
    restore_count = ras_cnt_t'(rc);
    @(negedge CLK);
    check_model(tag);
    @(posedge CLK);
    model_step(push, tgt, pop, rv, rp, rc);
    #1;
    idle_inputs();
  endtask

  task automatic push_c(input int tgt);
    cycle("push", 1'b1, tgt, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pop_c();
    cycle("pop", 1'b0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    check_const("por", 0, 0, 0, 0);
    #10;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // 1: reset asserted mid-stream clears state immediately
    for (int i = 1; i <= 5; i++) push_c(32'h10 + i);
    chk("t1_pre:count", 32'(ckpt_count), 32'd5);
    RST = 1'b1;
    #1;
    check_const("t1_async_rst", 0, 0, 0, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    pop_c();
    check_const("t1_pop_empty", 0, 0, 0, 0);

    // 2: three calls, then a return
    push_c(16'h0100);
    push_c(16'h0200);
    push_c(16'h0300);
    check_const("t2_pushed", 16'h0300, 1, 3, 3);
    pop_c();
    check_const("t2_popped", 16'h0200, 1, 2, 2);

    // 4: return-then-call on top 0x0200, count 2
    cycle("t4_pushpop", 1'b1, 16'h0444, 1'b1, 1'b0, 0, 0);
    check_const("t4_after", 16'h0444, 1, 2, 2);

    // 3: overflow wraps and saturates
    do_reset();
    for (int i = 1; i <= 9; i++) push_c(i);
    check_const("t3_full", 9, 1, 1, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_pop_target", 32'(ret_target), 32'(9 - i));
      pop_c();
    end
    check_const("t3_drained", 32'(m_mem[1]), 0, 1, 0);
    pop_c();
    chk("t3_extra_pop:ptr", 32'(ckpt_ptr), 32'd1);
    chk("t3_extra_pop:count", 32'(ckpt_count), 32'd0);

    // 5: restore beats a concurrent push
    do_reset();
    push_c(16'h0A);
    push_c(16'h0B);
    check_const("t5_ckpt", 16'h0B, 1, 2, 2);
    push_c(16'h0C);
    push_c(16'h0D);
    push_c(16'h0E);
    cycle("t5_restore", 1'b1, 16'h077, 1'b0, 1'b1, 2, 2);
    check_const("t5_after", 16'h0B, 1, 2, 2);

    // 6: restore after the checkpointed slot was overwritten
    do_reset();
    push_c(16'h0A);
    check_const("t6_ckpt", 16'h0A, 1, 1, 1);
    pop_c();
    push_c(16'h0F);
    cycle("t6_restore", 1'b0, 0, 1'b0, 1'b1, 1, 1);
    check_const("t6_after", 16'h0F, 1, 1, 1);

    // Random traffic, restoring to checkpoints that were genuinely handed out
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      int sel;
      logic pu;
      logic po;
      ck_ptr_q.push_back(m_ptr);
      ck_cnt_q.push_back(m_cnt);
      if (ck_ptr_q.size() > 12) begin
        void'(ck_ptr_q.pop_front());
        void'(ck_cnt_q.pop_front());
      end
      r  = int'($urandom_range(0, 99));
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 50);
      if (r < 8) begin
        sel = int'($urandom_range(0, ck_ptr_q.size() - 1));
        cycle("rnd_restore", pu, int'($urandom_range(0, 16'h3FFF)), po, 1'b1,
              ck_ptr_q[sel], ck_cnt_q[sel]);
      end else begin
        cycle("rnd", pu, int'($urandom_range(0, 16'h3FFF)), po, 1'b0, 0, 0);
      end
    end
    check_model("rnd_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
